// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the machine-mode interrupt controller: cause codes,
// mip bit positions and FSM state encodings.
package irq_ctrl_pkg;

  localparam logic [31:0] IRQ_CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] IRQ_CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] IRQ_CAUSE_MTI = 32'h8000_0007;

  localparam int MIP_MSIP_BIT = 3;
  localparam int MIP_MTIP_BIT = 7;
  localparam int MIP_MEIP_BIT = 11;

  typedef enum logic [1:0] {
    IRQ_ST_IDLE    = 2'd0,
    IRQ_ST_REQ     = 2'd1,
    IRQ_ST_SERVICE = 2'd2
  } irq_st_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: enabled {mei, mti, msi} -> {valid, mcause}.
// Priority is MEI > MSI > MTI.
module irq_prio_enc
  import irq_ctrl_pkg::*;
(
  input  logic [2:0]  en,
  output logic        valid,
  output logic [31:0] cause
);

  always_comb begin
    valid = |en;
    cause = '0;
    if (en[2])      cause = IRQ_CAUSE_MEI;
    else if (en[0]) cause = IRQ_CAUSE_MSI;
    else if (en[1]) cause = IRQ_CAUSE_MTI;
  end

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: registered mip, mie/MIE masking,
// fixed-priority selection and a req/ack/mret handshake towards excp.
// Define IRQ_EXT_EDGE_EN to make the external line edge-triggered and sticky.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_irq_i,
  input  logic        sw_irq_i,
  input  logic        ext_irq_i,
  input  logic [31:0] csr_mstatus_i,
  input  logic [31:0] csr_mie_i,
  input  logic        excp_busy_i,
  input  logic        irq_ack_i,
  input  logic        mret_i,
  output logic        irq_req_o,
  output logic [31:0] irq_cause_o,
  output logic [31:0] csr_mip_o,
  output logic        irq_timeout_o
);

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(ACK_TIMEOUT - 1);

  irq_st_e          state, state_nxt;
  logic [31:0]      mip, mip_d;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [2:0]       en;
  logic             win_vld;
  logic [31:0]      win_cause;
  logic             ext_pend;

`ifdef IRQ_EXT_EDGE_EN
  logic ext_q, ext_pend_q, ext_clr;

  assign ext_clr = (state == IRQ_ST_REQ) && irq_ack_i && (irq_cause_o == IRQ_CAUSE_MEI);

  // A fresh rising edge wins over the ack-side clear so no edge is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q      <= 1'b0;
      ext_pend_q <= 1'b0;
    end else begin
      ext_q <= ext_irq_i;
      if (ext_irq_i && !ext_q) ext_pend_q <= 1'b1;
      else if (ext_clr)        ext_pend_q <= 1'b0;
    end
  end

  assign ext_pend = ext_pend_q;
`else
  assign ext_pend = ext_irq_i;
`endif

  always_comb begin
    mip_d               = '0;
    mip_d[MIP_MSIP_BIT] = sw_irq_i;
    mip_d[MIP_MTIP_BIT] = timer_irq_i;
    mip_d[MIP_MEIP_BIT] = ext_pend;
  end

  assign en = {mip[MIP_MEIP_BIT] & csr_mie_i[MIP_MEIP_BIT],
               mip[MIP_MTIP_BIT] & csr_mie_i[MIP_MTIP_BIT],
               mip[MIP_MSIP_BIT] & csr_mie_i[MIP_MSIP_BIT]} & {3{csr_mstatus_i[3]}};

  irq_prio_enc u_prio (
    .en    (en),
    .valid (win_vld),
    .cause (win_cause)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IRQ_ST_IDLE:    if (win_vld && !excp_busy_i) state_nxt = IRQ_ST_REQ;
      IRQ_ST_REQ:     if (irq_ack_i)               state_nxt = IRQ_ST_SERVICE;
      IRQ_ST_SERVICE: if (mret_i)                  state_nxt = IRQ_ST_IDLE;
      default:                                     state_nxt = IRQ_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IRQ_ST_IDLE;
    else     state <= state_nxt;
  end

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      mip           <= '0;
      cnt           <= '0;
      irq_cause_o   <= '0;
      irq_timeout_o <= 1'b0;
    end else begin
      mip <= mip_d;
      if (state == IRQ_ST_IDLE && state_nxt == IRQ_ST_REQ) begin
        irq_cause_o <= win_cause;
        cnt         <= '0;
      end else if (state == IRQ_ST_REQ && !irq_ack_i) begin
        cnt <= cnt_inc;
        // Timeout becomes visible in the REQ cycle whose counter equals the limit.
        if (cnt_inc >= TO_LIM) irq_timeout_o <= 1'b1;
      end
      if (state == IRQ_ST_SERVICE && mret_i) irq_cause_o <= '0;
    end
  end

  assign irq_req_o = (state == IRQ_ST_REQ);
  assign csr_mip_o = mip;

  logic unused_bits;
  assign unused_bits = ^{csr_mstatus_i[31:4], csr_mstatus_i[2:0], csr_mie_i[31:12],
                         csr_mie_i[10:8], csr_mie_i[6:4], csr_mie_i[2:0]};

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: table of steady-state vectors plus hand-written
// handshake, timeout, reset and external-pulse sequences, checked via a queue.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        timer_irq_i, sw_irq_i, ext_irq_i;
  logic [31:0] csr_mstatus_i, csr_mie_i;
  logic        excp_busy_i, irq_ack_i, mret_i;
  logic        irq_req_o;
  logic [31:0] irq_cause_o, csr_mip_o;
  logic        irq_timeout_o;

  irq_ctrl #(.ACK_TIMEOUT(16), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .timer_irq_i   (timer_irq_i),
    .sw_irq_i      (sw_irq_i),
    .ext_irq_i     (ext_irq_i),
    .csr_mstatus_i (csr_mstatus_i),
    .csr_mie_i     (csr_mie_i),
    .excp_busy_i   (excp_busy_i),
    .irq_ack_i     (irq_ack_i),
    .mret_i        (mret_i),
    .irq_req_o     (irq_req_o),
    .irq_cause_o   (irq_cause_o),
    .csr_mip_o     (csr_mip_o),
    .irq_timeout_o (irq_timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        t, s, e;
    logic [31:0] ms, mie;
    logic [31:0] exp_mip;
    logic        exp_req;
    logic [31:0] exp_cause;
  } vec_t;

  typedef struct {
    string       nm;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  pass_cnt = 0;
  int  tot_cnt  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic push(input string nm, input logic [31:0] exp);
    sb_t e;
    e.nm  = nm;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] act);
    sb_t e;
    if (sb.size() == 0) begin
      tot_cnt++;
      $display("FAIL sb_empty: got %h, expected a queued value", act);
    end else begin
      e = sb.pop_front();
      chk(e.nm, act, e.exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {timer_irq_i, sw_irq_i, ext_irq_i, excp_busy_i, irq_ack_i, mret_i} = '0;
    csr_mstatus_i = '0;
    csr_mie_i     = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string nm, input int budget);
    int n = 0;
    while (!irq_req_o && n < budget) begin
      tick();
      n++;
    end
    if (!irq_req_o) chk({nm, "_wait_timeout"}, 32'(irq_req_o), 32'd1);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1,0,0, 32'h8,         32'h080, 32'h080, 1, 32'h8000_0007};
    vecs[1] = '{0,1,0, 32'h8,         32'h008, 32'h008, 1, 32'h8000_0003};
    vecs[2] = '{0,0,1, 32'h8,         32'h800, 32'h800, 1, 32'h8000_000B};
    vecs[3] = '{1,1,1, 32'h8,         32'h888, 32'h888, 1, 32'h8000_000B};
    vecs[4] = '{1,1,0, 32'h8,         32'h888, 32'h088, 1, 32'h8000_0003};
    vecs[5] = '{1,1,1, 32'h8,         32'h088, 32'h888, 1, 32'h8000_0003};
    vecs[6] = '{1,0,1, 32'h8,         32'h080, 32'h880, 1, 32'h8000_0007};
    vecs[7] = '{1,1,1, 32'h0,         32'h888, 32'h888, 0, 32'h0};
    vecs[8] = '{1,0,0, 32'h8,         32'h008, 32'h080, 0, 32'h0};
    vecs[9] = '{0,0,0, 32'hFFFF_FFFF, 32'hFFF, 32'h000, 0, 32'h0};

    // reset values
    do_reset();
    rst = 1'b1;
    tick();
    push("rst_req", 0);   pop_chk(32'(irq_req_o));
    push("rst_cause", 0); pop_chk(irq_cause_o);
    push("rst_mip", 0);   pop_chk(csr_mip_o);
    push("rst_to", 0);    pop_chk(32'(irq_timeout_o));
    rst = 1'b0;

    // steady-state vectors: two cycles after driving, mip and request are settled
    for (int i = 0; i < 10; i++) begin
      do_reset();
      timer_irq_i = vecs[i].t; sw_irq_i = vecs[i].s; ext_irq_i = vecs[i].e;
      csr_mstatus_i = vecs[i].ms; csr_mie_i = vecs[i].mie;
      push($sformatf("vec%0d_req", i), 32'(vecs[i].exp_req));
      push($sformatf("vec%0d_cause", i), vecs[i].exp_cause);
      push($sformatf("vec%0d_mip", i), vecs[i].exp_mip);
      tick();
      tick();
      pop_chk(32'(irq_req_o));
      pop_chk(irq_cause_o);
      pop_chk(csr_mip_o);
    end

    // timer latency, mret ignored in REQ, simultaneous ack+mret -> SERVICE
    do_reset();
    csr_mstatus_i = 32'h8; csr_mie_i = 32'h80; timer_irq_i = 1'b1;
    tick();                                   // cycle 1
    chk("t_c1_req", 32'(irq_req_o), 0);
    tick();                                   // cycle 2
    chk("t_c2_req", 32'(irq_req_o), 1);
    chk("t_c2_cause", irq_cause_o, 32'h8000_0007);
    mret_i = 1'b1;
    tick();                                   // cycle 3
    mret_i = 1'b0;
    chk("t_mret_in_req", 32'(irq_req_o), 1);
    irq_ack_i = 1'b1; mret_i = 1'b1;
    tick();                                   // cycle 4
    irq_ack_i = 1'b0; mret_i = 1'b0;
    tick();                                   // cycle 5
    chk("t_c5_req", 32'(irq_req_o), 0);
    chk("t_svc_cause", irq_cause_o, 32'h8000_0007);
    tick(); tick();
    chk("t_svc_hold", 32'(irq_req_o), 0);
    irq_ack_i = 1'b1;                         // ack ignored in SERVICE
    tick();
    irq_ack_i = 1'b0;
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    chk("t_mret_idle_req", 32'(irq_req_o), 0);
    chk("t_mret_idle_cause", irq_cause_o, 0);
    tick();
    chk("t_rereq", 32'(irq_req_o), 1);

    // priority: MEI first, then MSI once ext drops
    do_reset();
    csr_mstatus_i = 32'h8; csr_mie_i = 32'h888;
    {timer_irq_i, sw_irq_i, ext_irq_i} = 3'b111;
    wait_req("prio1", 8);
    chk("prio_mei", irq_cause_o, 32'h8000_000B);
    ext_irq_i = 1'b0; irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    tick();
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    wait_req("prio2", 8);
    chk("prio_msi", irq_cause_o, 32'h8000_0003);

    // MIE clear: no request for 20 cycles, mip still visible
    do_reset();
    csr_mstatus_i = 32'h0; csr_mie_i = 32'h888;
    {timer_irq_i, sw_irq_i, ext_irq_i} = 3'b111;
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (irq_req_o) seen++;
      end
      chk("mask_no_req", seen, 0);
    end
    chk("mask_mip", csr_mip_o, 32'h888);

    // excp busy blocks issue; ack in IDLE ignored
    do_reset();
    csr_mstatus_i = 32'h8; csr_mie_i = 32'h80; timer_irq_i = 1'b1; excp_busy_i = 1'b1;
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    tick(); tick(); tick();
    chk("busy_no_req", 32'(irq_req_o), 0);
    excp_busy_i = 1'b0;
    tick();
    chk("busy_release_req", 32'(irq_req_o), 1);

    // ack timeout on the 16th REQ cycle, sticky across ack, cleared by rst
    do_reset();
    csr_mstatus_i = 32'h8; csr_mie_i = 32'h8; sw_irq_i = 1'b1;
    wait_req("to", 8);                        // REQ cycle 1
    for (int k = 2; k <= 15; k++) tick();
    chk("to_c15", 32'(irq_timeout_o), 0);
    tick();
    chk("to_c16", 32'(irq_timeout_o), 1);
    chk("to_req_held", 32'(irq_req_o), 1);
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    tick();
    chk("to_sticky", 32'(irq_timeout_o), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("to_rst_clear", 32'(irq_timeout_o), 0);

    // rst during SERVICE, re-request two cycles after release
    do_reset();
    csr_mstatus_i = 32'h8; csr_mie_i = 32'h80; timer_irq_i = 1'b1;
    wait_req("rs", 8);
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_req", 32'(irq_req_o), 0);
    chk("rs_cause", irq_cause_o, 0);
    chk("rs_mip", csr_mip_o, 0);
    tick();
    chk("rs_rel1", 32'(irq_req_o), 0);
    tick();
    chk("rs_rel2", 32'(irq_req_o), 1);

    // one-cycle ext pulse while in SERVICE
    do_reset();
    csr_mstatus_i = 32'h8; csr_mie_i = 32'h800; ext_irq_i = 1'b1;
    wait_req("ext", 8);
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0; ext_irq_i = 1'b0;
    tick(); tick();
    ext_irq_i = 1'b1;
    tick();
    ext_irq_i = 1'b0;
    tick(); tick();
`ifdef IRQ_EXT_EDGE_EN
    chk("ext_mip_held", 32'(csr_mip_o[11]), 1);
`else
    chk("ext_mip_held", 32'(csr_mip_o[11]), 0);
`endif
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    tick();
`ifdef IRQ_EXT_EDGE_EN
    chk("ext_pulse_req", 32'(irq_req_o), 1);
    chk("ext_pulse_cause", irq_cause_o, 32'h8000_000B);
`else
    chk("ext_pulse_req", 32'(irq_req_o), 0);
    chk("ext_pulse_cause", irq_cause_o, 0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
